// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - state encoding, register layout, reset values and default melody for alarm_tone_gen
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_GAP    = 2'd2,
      ST_SNOOZE = 2'd3
   } state_t;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_SNOOZE_BIT = 1;
   localparam int CTRL_MUTE_BIT   = 2;

   localparam logic [7:0] CTRL_RST  = 8'h01;
   localparam logic [7:0] TEMPO_RST = 8'd63;

   // Each ROM word is {half_period[31:0], dur[3:0]}; the top keeps only DIV_W period bits.
   localparam int ROM_DEPTH   = 16;
   localparam int ROM_HP_W    = 32;
   localparam int ROM_ENTRY_W = ROM_HP_W + 4;

   typedef logic [ROM_DEPTH-1:0][ROM_ENTRY_W-1:0] rom_t;

   function automatic logic [ROM_ENTRY_W-1:0] note(input int unsigned hp, input int unsigned dur);
      logic [ROM_HP_W-1:0] hp_v;
      logic [3:0]          dur_v;
      hp_v  = hp;
      dur_v = dur[3:0];
      return {hp_v, dur_v};
   endfunction

   // Short C-major arpeggio at 50 MHz, ending on a rest so the loop is audible.
   function automatic rom_t default_melody();
      rom_t rom;
      rom    = '0;
      rom[0] = note(47801, 1);
      rom[1] = note(37936, 1);
      rom[2] = note(31888, 1);
      rom[3] = note(23889, 3);
      rom[4] = note(0,     1);
      rom[5] = note(23889, 1);
      rom[6] = note(31888, 1);
      rom[7] = note(0,     3);
      return rom;
   endfunction

endpackage

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - clock-enabled square-wave oscillator; restarts low whenever disabled or the note changes
module tone_osc #(
   parameter int DIV_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mute,
   input  logic [DIV_W-1:0] half_period,
   output logic             wave
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] hp_q;
   logic             phase;
   logic             phase_d;
   logic             restart;
   logic             hit;

   // A zero half-period is a rest, so it behaves like a permanent restart.
   assign restart = !en || (half_period == '0) || (half_period != hp_q);
   assign hit     = (cnt == half_period - DIV_W'(1));
   assign phase_d = restart ? 1'b0 : (hit ? ~phase : phase);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         hp_q  <= '0;
         phase <= 1'b0;
         wave  <= 1'b0;
      end else begin
         hp_q  <= half_period;
         phase <= phase_d;
         wave  <= phase_d & ~mute;
         if (restart || hit) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - alarm melody player on the PicoBlaze port bus; ALARM_SNOOZE_EN adds the snooze control
module alarm_tone_gen
   import alarm_pkg::*;
#(
   parameter int         NOTES        = 8,
   parameter int         DIV_W        = 18,
   parameter int         BEAT_SHIFT   = 16,
   parameter int         GAP_CLKS     = 1024,
   parameter int         SNOOZE_BEATS = 64,
   parameter logic [7:0] ADDR_CTRL    = 8'h40,
   parameter logic [7:0] ADDR_TEMPO   = 8'h41,
   parameter rom_t       MELODY       = default_melody()
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] POR_ID,
   input  logic [7:0] OUT_PORT,
   input  logic       WRITE_STROBE,
   input  logic       ALARMA,
   output logic       speaker,
   output logic       busy
);

   localparam int IDX_W = (NOTES > 1) ? $clog2(NOTES) : 1;
   localparam int BW    = 8 + BEAT_SHIFT;
   localparam int GW    = $clog2(GAP_CLKS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES - 1);

   state_t           state;
   state_t           state_next;
   logic             enable;
   logic             mute;
   logic [7:0]       tempo;
   logic [7:0]       tempo_cur;
   logic [IDX_W-1:0] index;
   logic [3:0]       rom_addr;
   logic [BW-1:0]    beat_cnt;
   logic [BW-1:0]    beat_last;
   logic [3:0]       note_beat;
   logic [3:0]       dur;
   logic [GW-1:0]    gap_cnt;
   logic [DIV_W-1:0] half_period;
   logic             ctrl_wr;
   logic             tempo_wr;
   logic             mute_eff;
   logic             beat_run;
   logic             beat_tick;
   logic             note_done;
   logic             gap_done;
   logic             osc_en;
   logic             unused_port;

   assign ctrl_wr  = WRITE_STROBE && (POR_ID == ADDR_CTRL);
   assign tempo_wr = WRITE_STROBE && (POR_ID == ADDR_TEMPO);

   assign rom_addr    = 4'(index);
   assign half_period = MELODY[rom_addr][4 +: DIV_W];
   assign dur         = MELODY[rom_addr][3:0];

   // (tempo+1) << BEAT_SHIFT clocks per beat, so the last count is tempo followed by ones.
   assign beat_last = {tempo_cur, {BEAT_SHIFT{1'b1}}};
   assign beat_tick = (beat_cnt == beat_last);
   assign note_done = beat_tick && (note_beat == dur);
   assign gap_done  = (gap_cnt == GW'(GAP_CLKS - 1));

   assign unused_port = ^OUT_PORT[7:3];

   always_ff @(posedge CLK) begin
      if (RST) begin
         enable <= CTRL_RST[CTRL_EN_BIT];
         mute   <= CTRL_RST[CTRL_MUTE_BIT];
         tempo  <= TEMPO_RST;
      end else begin
         if (ctrl_wr) begin
            enable <= OUT_PORT[CTRL_EN_BIT];
            mute   <= OUT_PORT[CTRL_MUTE_BIT];
         end
         if (tempo_wr) begin
            tempo <= OUT_PORT;
         end
      end
   end

`ifdef ALARM_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_BEATS) + 1;

   logic          snooze_req;
   logic          snooze_done;
   logic [SW-1:0] snooze_cnt;

   assign snooze_done = beat_tick && (snooze_cnt == SW'(SNOOZE_BEATS - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         snooze_req <= 1'b0;
         snooze_cnt <= '0;
      end else begin
         snooze_req <= ctrl_wr && OUT_PORT[CTRL_SNOOZE_BIT];
         if ((state == ST_SNOOZE) && (state_next == ST_SNOOZE)) begin
            if (beat_tick) begin
               snooze_cnt <= snooze_cnt + SW'(1);
            end
         end else begin
            snooze_cnt <= '0;
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = OUT_PORT[CTRL_SNOOZE_BIT] ^ (SNOOZE_BEATS == 0);
`endif

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (ALARMA && enable) state_next = ST_PLAY;
         end
         ST_PLAY: begin
            if (note_done) state_next = ST_GAP;
`ifdef ALARM_SNOOZE_EN
            if (snooze_req) state_next = ST_SNOOZE;
`endif
         end
         ST_GAP: begin
            if (gap_done) state_next = ST_PLAY;
`ifdef ALARM_SNOOZE_EN
            if (snooze_req) state_next = ST_SNOOZE;
`endif
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE: begin
            if (snooze_done) state_next = ST_PLAY;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
      // Dropping the alarm or the enable beats any pending snooze.
      if (!ALARMA || !enable) state_next = ST_IDLE;
   end

   assign beat_run = ((state == ST_PLAY) || (state == ST_SNOOZE)) && (state_next == state);
   assign osc_en   = (state == ST_PLAY) && (state_next == ST_PLAY);
   assign mute_eff = ctrl_wr ? OUT_PORT[CTRL_MUTE_BIT] : mute;
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         index     <= '0;
         beat_cnt  <= '0;
         tempo_cur <= TEMPO_RST;
         note_beat <= '0;
         gap_cnt   <= '0;
      end else begin
         state <= state_next;

         // A new tempo is only picked up when a beat starts.
         if (!beat_run || beat_tick) begin
            beat_cnt  <= '0;
            tempo_cur <= tempo;
         end else begin
            beat_cnt <= beat_cnt + BW'(1);
         end

         if ((state != ST_PLAY) || !beat_run) begin
            note_beat <= '0;
         end else if (beat_tick) begin
            note_beat <= note_beat + 4'd1;
         end

         if ((state == ST_GAP) && (state_next == ST_GAP)) begin
            gap_cnt <= gap_cnt + GW'(1);
         end else begin
            gap_cnt <= '0;
         end

         // Advancing on gap entry lets the oscillator see the new period before the note starts.
         if ((state_next == ST_IDLE) || (state_next == ST_SNOOZE)) begin
            index <= '0;
         end else if ((state == ST_PLAY) && (state_next == ST_GAP)) begin
            index <= (index == LAST_IDX) ? '0 : index + IDX_W'(1);
         end
      end
   end

   tone_osc #(
      .DIV_W(DIV_W)
   ) u_tone_osc (
      .clk        (CLK),
      .rst        (RST),
      .en         (osc_en),
      .mute       (mute_eff),
      .half_period(half_period),
      .wave       (speaker)
   );

endmodule

// File: doc/alarm_tone_gen.md
# alarm_tone_gen

Parametrised alarm melody generator that drives the RTC board speaker while the alarm is active. It sits beside the VGA and PS/2 keyboard blocks on the same PicoBlaze port bus (POR_ID/OUT_PORT/WRITE_STROBE). It replaces the gated-clock tone source with a single-clock, clock-enabled design. It adds a programmable tempo, a mute control, a snooze control and a configurable melody length.

## Interface
- NOTES, 8: melody length (2..16); ROM index width = clog2(NOTES).
- DIV_W, 18: width of the tone half-period field, in clocks.
- BEAT_SHIFT, 16: one beat = (tempo+1) << BEAT_SHIFT clocks.
- GAP_CLKS, 1024: silence between consecutive notes, in clocks (≥1).
- SNOOZE_BEATS, 64: snooze length, in beats.
- ADDR_CTRL, 8'h40: port address of the control register.
- ADDR_TEMPO, 8'h41: port address of the tempo register.
- CLK  in  1: system clock; all logic on its rising edge.
- RST  in  1: synchronous, active-high reset.
- POR_ID  in  8: port address.
- OUT_PORT  in  8: write data.
- WRITE_STROBE  in  1: one-cycle write qualifier.
- ALARMA  in  1: alarm request, level-sensitive, synchronous to CLK.
- speaker  out  1: square-wave speaker drive, registered.
- busy  out  1: high in any state other than IDLE.

## Operation
- Registers:
  - CTRL bit0 = enable, bit1 = snooze strobe (self-clearing, reads as 0), bit2 = mute; other bits ignored.
  - TEMPO is 8 bits.
  - A write is accepted when WRITE_STROBE=1 and POR_ID matches; other addresses are ignored.
- Melody ROM: NOTES entries of {half_period[DIV_W-1:0], dur[3:0]}.
  - Note length = (dur+1) beats.
  - half_period=0 is a rest: speaker held 0 for that note.
- States:
  - IDLE → PLAY when ALARMA=1 and enable=1. Note index := 0; beat and tone counters cleared.
  - PLAY: speaker toggles every half_period clocks unless mute=1 (mute holds speaker 0). When the note length expires → GAP.
  - GAP: speaker 0 for GAP_CLKS clocks → PLAY with next index. Index wraps NOTES-1 → 0; the melody loops indefinitely.
  - SNOOZE: speaker 0 for SNOOZE_BEATS beats → PLAY at index 0.
- Entering SNOOZE: a snooze write in PLAY or GAP goes to SNOOZE. A snooze write in IDLE or SNOOZE is ignored; the snooze timer is not restarted.
- Return to IDLE: from any state, ALARMA=0 or enable=0 sends the block to IDLE on the next edge with speaker 0. This has priority over a simultaneous snooze write.
- Tempo change: takes effect at the next beat boundary. The current beat completes with the old value.
- Arithmetic: the beat counter is 8+BEAT_SHIFT bits and counts 0..((tempo+1)<<BEAT_SHIFT)-1 with no overflow. The tone counter is DIV_W bits.

## Timing
- Reset values: speaker=0, busy=0, state=IDLE, CTRL=8'h01 (enabled, unmuted), TEMPO=8'd63, index=0, all counters 0.
- Reset mid-melody returns to IDLE in one cycle. The melody restarts at index 0 on the next ALARMA=1.
- Register writes are visible to the FSM on the cycle after the strobe.
- Start latency: ALARMA rising at edge n gives busy=1 after edge n+1. The first speaker toggle occurs half_period cycles later.
- Stop latency: speaker=0 and busy=0 one cycle after ALARMA falls.
- Mute affects speaker one cycle after the write; the timing counters keep running.

## Configuration
- ALARM_SNOOZE_EN defined: snooze bit and SNOOZE state implemented as above.
- Not defined: CTRL bit1 is ignored, the SNOOZE state and its counter are not synthesised, and SNOOZE_BEATS is unused.

## Structure
- Package alarm_pkg holds:
  - the state encoding (IDLE, PLAY, GAP, SNOOZE);
  - CTRL bit positions;
  - reset constants for CTRL and TEMPO;
  - the default melody ROM contents function.
- Sub-module tone_osc: enable plus half_period in, square wave out. Restarts low on any change of note.

## Test plan
- Bench parameters: NOTES=4, BEAT_SHIFT=2, GAP_CLKS=4, SNOOZE_BEATS=2, TEMPO=0 (beat = 4 clocks). ROM = {(3,0),(0,1),(5,0),(2,0)}.
- Reset then ALARMA=1: busy=1 after 1 cycle; speaker toggles every 3 clocks for 4 clocks; GAP of 4 clocks at 0; note 1 is a rest held at 0 for 8 clocks; index wraps after note 3 back to note 0.
- Snooze write (OUT_PORT=8'h03 to 8'h40) during PLAY: speaker 0 for 8 clocks, then note 0 restarts. Compiled without ALARM_SNOOZE_EN: playback continues uninterrupted.
- Mute write (8'h05) mid-note: speaker 0 next cycle while note timing continues. Unmute (8'h01): toggling resumes at the correct index.
- ALARMA falls in the same cycle as a snooze write: IDLE, speaker=0, busy=0 next cycle; no SNOOZE entry.
- TEMPO write 8'h01 mid-beat: the current beat stays 4 clocks; following beats are 8 clocks. A write to address 8'h42 changes nothing.
